slot_game_ctrl: RTL
===================

Name: slot_game_ctrl

Overview:
Game sequencer for the slot machine. Holds the player credit balance and accepts coin and spin requests. It selects one of two spin engines (mode1/mode2) over a shared start/out/won interface, holds start for a fixed spin window, then samples the engine's out/won after a settle delay. It pays out winnings by mode and presents a latched result to the display logic.

Parameters:
CREDIT_W, 8, credit counter width; balance saturates at 2^CREDIT_W-1
SPIN_CYCLES, 64, cycles eng_start is held high per spin (>=1)
SETTLE_CYCLES, 2, cycles between eng_start falling and result sampling (>=1)
PAYOUT_M1, 5, credits paid on a mode1 win
PAYOUT_M2, 10, credits paid on a mode2 win

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
coin_in  in  1  one-cycle pulse; adds 1 credit
spin_req  in  1  level or pulse; request a spin (sampled in IDLE only)
mode_sel  in  1  0=mode1, 1=mode2; sampled with accepted spin_req
eng_out  in  10  result value from selected engine
eng_won  in  1  win flag from selected engine
eng_start  out  1  start to engines (registered)
eng_sel  out  1  latched engine select; routes eng_start and the eng_out/eng_won mux
credits  out  CREDIT_W  current balance
result  out  10  last sampled eng_out
busy  out  1  high whenever state != IDLE
win_pulse  out  1  one-cycle pulse when a payout is applied
no_credit  out  1  one-cycle pulse when spin_req is refused

Behaviour:
- Reset: state=IDLE, credits=0, result=0, eng_start=0, eng_sel=0, win_pulse=0, no_credit=0, counters=0. Reset mid-spin aborts immediately; the spent credit is not refunded.
- States: IDLE, SPIN, SETTLE, PAYOUT.
- IDLE, spin_req=1, credits>=1 (edge E0):
  - state<=SPIN, cnt<=SPIN_CYCLES-1, eng_start<=1.
  - eng_sel<=mode_sel, credits decremented by 1.
- IDLE, spin_req=1, credits==0: no_credit<=1 for one cycle; state stays IDLE.
- SPIN: cnt decrements each cycle. At cnt==0: eng_start<=0, state<=SETTLE, cnt<=SETTLE_CYCLES-1. eng_start is therefore high for exactly SPIN_CYCLES cycles.
- SETTLE: cnt decrements. At cnt==0: result<=eng_out, won_lat<=eng_won, state<=PAYOUT.
- PAYOUT (one cycle): if won_lat, credits += (eng_sel ? PAYOUT_M2 : PAYOUT_M1) and win_pulse<=1. state<=IDLE.
- Latency: result valid after edge E(SPIN_CYCLES+SETTLE_CYCLES). Credit update, win_pulse and busy falling after edge E(SPIN_CYCLES+SETTLE_CYCLES+1), i.e. E67 with defaults.
- spin_req outside IDLE is ignored, not queued. mode_sel changes mid-spin have no effect.
- coin_in is accepted in every state, including during reset release.
- Simultaneous events are combined into one net update per cycle:
  - coin at accept edge: credits += 1 - 1 (unchanged).
  - coin in PAYOUT cycle: credits += payout + 1.
- Arithmetic: compute at CREDIT_W+5 bits. Saturate at 2^CREDIT_W-1 on add; never underflow.
- win_pulse and no_credit are never high together. Both last exactly one cycle.

Optional Feature:
FREE_PLAY_EN
- Defined: spins are accepted regardless of balance, no credit is charged, no_credit is tied 0, and payouts are still added (saturating).
- Undefined: credit rules as above.

Test Plan:
1. rst=1 two cycles, release, 3 coin_in pulses -> credits=3, busy=0, eng_start=0, result=0.
2. credits=3, spin_req with mode_sel=1, engine drives eng_out=10'd777, eng_won=1:
   - eng_start high exactly 64 cycles; eng_sel=1.
   - result=777 after E66.
   - credits=2 then 12 at E67, with a single win_pulse.
3. credits=0, spin_req -> no_credit one cycle, state stays IDLE, credits=0, eng_start never rises.
4. credits=250, mode1 win, coin_in pulsed in the PAYOUT cycle -> credits saturate at 255, no wrap.
5. Mid-spin:
   - spin_req and mode_sel toggled at cycle 30 -> ignored; eng_sel unchanged; one spin only.
   - rst at cycle 40 -> eng_start=0 next edge, state IDLE, credits=0.
6. Coin pulse on the same edge as spin acceptance with credits=1 -> credits=1 after edge. With FREE_PLAY_EN defined and credits=0, spin runs and a mode2 win gives credits=10.

Source files
------------

// File: rtl/slot_game_ctrl_if.sv
// Shared spin-engine bus: start/select from the controller, out/won back from the selected engine.
interface slot_game_ctrl_if;
    logic       eng_start;
    logic       eng_sel;
    logic [9:0] eng_out;
    logic       eng_won;

    modport master (
        output eng_start,
        output eng_sel,
        input  eng_out,
        input  eng_won
    );

    modport slave (
        input  eng_start,
        input  eng_sel,
        output eng_out,
        output eng_won
    );
endinterface

// File: rtl/slot_game_ctrl.sv
// Slot machine game sequencer: credit balance, spin timing, result sampling and payout.
// Optional macro FREE_PLAY_EN: spins are accepted without charging credit; no_credit is tied low.
module slot_game_ctrl #(
    parameter int unsigned CREDIT_W      = 8,
    parameter int unsigned SPIN_CYCLES   = 64,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PAYOUT_M1     = 5,
    parameter int unsigned PAYOUT_M2     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coin_in,
    input  logic                    spin_req,
    input  logic                    mode_sel,
    slot_game_ctrl_if.master        eng,
    output logic [CREDIT_W-1:0]     credits,
    output logic [9:0]              result,
    output logic                    busy,
    output logic                    win_pulse,
    output logic                    no_credit
);

    localparam int unsigned CNT_MAX = (SPIN_CYCLES > SETTLE_CYCLES) ? SPIN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned SUM_W   = CREDIT_W + 5;
    localparam logic [SUM_W-1:0] SAT_MAX = {{5{1'b0}}, {CREDIT_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        SETTLE,
        PAYOUT
    } state_t;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [CREDIT_W-1:0] r_credits, w_credits;
    logic [9:0]          r_result, w_result;
    logic                r_start, w_start;
    logic                r_sel, w_sel;
    logic                r_won, w_won;
    logic                r_win, w_win;
    logic                r_nocr, w_nocr;
    logic                w_accept;
    logic                w_charge;
    logic [SUM_W-1:0]    w_add;
    logic [SUM_W-1:0]    w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_credits <= '0;
            r_result  <= '0;
            r_start   <= 1'b0;
            r_sel     <= 1'b0;
            r_won     <= 1'b0;
            r_win     <= 1'b0;
            r_nocr    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_credits <= w_credits;
            r_result  <= w_result;
            r_start   <= w_start;
            r_sel     <= w_sel;
            r_won     <= w_won;
            r_win     <= w_win;
            r_nocr    <= w_nocr;
        end
    end

    // Spin acceptance decision; charging is separated so free play only changes this block.
    always_comb begin
        w_accept = 1'b0;
        w_charge = 1'b0;
        w_nocr   = 1'b0;
        if (r_state == IDLE && spin_req) begin
`ifdef FREE_PLAY_EN
            w_accept = 1'b1;
`else
            if (r_credits != '0) begin
                w_accept = 1'b1;
                w_charge = 1'b1;
            end else begin
                w_nocr = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_result = r_result;
        w_start  = r_start;
        w_sel    = r_sel;
        w_won    = r_won;
        w_win    = 1'b0;
        w_add    = SUM_W'(coin_in);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state = SPIN;
                    w_cnt   = CNT_W'(SPIN_CYCLES - 1);
                    w_start = 1'b1;
                    w_sel   = mode_sel;
                end
            end
            SPIN: begin
                if (r_cnt == '0) begin
                    w_state = SETTLE;
                    w_cnt   = CNT_W'(SETTLE_CYCLES - 1);
                    w_start = 1'b0;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_state  = PAYOUT;
                    w_result = eng.eng_out;
                    w_won    = eng.eng_won;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            PAYOUT: begin
                if (r_won) begin
                    w_add = w_add + (r_sel ? SUM_W'(PAYOUT_M2) : SUM_W'(PAYOUT_M1));
                    w_win = 1'b1;
                end
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    // Coin, charge and payout fold into one net update; a charge implies balance >= 1, so no underflow.
    always_comb begin
        w_sum     = {{5{1'b0}}, r_credits} + w_add - SUM_W'(w_charge);
        w_credits = (w_sum > SAT_MAX) ? {CREDIT_W{1'b1}} : w_sum[CREDIT_W-1:0];
    end

    assign eng.eng_start = r_start;
    assign eng.eng_sel   = r_sel;
    assign credits       = r_credits;
    assign result        = r_result;
    assign busy          = (r_state != IDLE);
    assign win_pulse     = r_win;
    assign no_credit     = r_nocr;

endmodule
